// File: rtl/sram_arb_pkg.sv
// ============================================================================
// Module  : sram_arb_pkg
// Brief   : Shared types and default constants for the SRAM port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arb_pkg;

  localparam int c_ADDR_W      = 32;
  localparam int c_DATA_W      = 32;
  localparam int c_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_A = 3'd1,
    BUSY_B = 3'd2,
    DONE_A = 3'd3,
    DONE_B = 3'd4
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

endpackage

`default_nettype wire

// File: rtl/sram_arb_watchdog.sv
// ============================================================================
// Module  : sram_arb_watchdog
// Brief   : Clear/enable cycle counter with a terminal-count flag at
//           TIMEOUT_CYC-1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_watchdog
  import sram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;
  assign tc  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module  : sram_port_arbiter
// Brief   : Two-port round-robin arbiter in front of one SRAM controller port,
//           holding each grant until completion, with a watchdog abort.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = c_ADDR_W,
  parameter int DATA_W      = c_DATA_W,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_r_en,
  input  logic              a_w_en,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ready,
  input  logic              b_r_en,
  input  logic              b_w_en,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ready,
  output logic              m_r_en,
  output logic              m_w_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t r_state, w_state_nxt;
  port_id_t   r_last_grant, w_last_grant_nxt;

  logic               w_req_a, w_req_b;
  logic               w_busy_a, w_busy_b, w_busy;
  logic               w_sel_r_en, w_sel_w_en, w_sel_is_read;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [c_CNT_W-1:0] w_wd_cnt;
  logic               w_wd_tc;
  logic               w_complete, w_timeout;
  logic [DATA_W-1:0]  r_a_rdata, r_b_rdata;
  logic               r_err;

  assign w_req_a  = a_r_en | a_w_en;
  assign w_req_b  = b_r_en | b_w_en;
  assign w_busy_a = (r_state == BUSY_A);
  assign w_busy_b = (r_state == BUSY_B);
  assign w_busy   = w_busy_a | w_busy_b;

  // Only the granted port reaches the controller; the other is ignored.
  assign w_sel_r_en    = w_busy_b ? b_r_en  : a_r_en;
  assign w_sel_w_en    = w_busy_b ? b_w_en  : a_w_en;
  assign w_sel_addr    = w_busy_b ? b_addr  : a_addr;
  assign w_sel_wdata   = w_busy_b ? b_wdata : a_wdata;
  assign w_sel_is_read = w_sel_r_en & ~w_sel_w_en;

  assign m_w_en  = w_busy & w_sel_w_en;
  assign m_r_en  = w_busy & w_sel_is_read;
  assign m_addr  = w_busy ? w_sel_addr  : '0;
  assign m_wdata = w_busy ? w_sel_wdata : '0;

  sram_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (c_CNT_W)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (~w_busy),
    .en  (w_busy),
    .cnt (w_wd_cnt),
    .tc  (w_wd_tc)
  );

  // m_ready in the first busy cycle is the controller's stale idle status.
  assign w_complete = w_busy & m_ready & (|w_wd_cnt);
  assign w_timeout  = w_busy & w_wd_tc & ~w_complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_B;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_req_a && (!w_req_b || r_last_grant == PORT_B)) begin
          w_state_nxt      = BUSY_A;
          w_last_grant_nxt = PORT_A;
        end else if (w_req_b) begin
          w_state_nxt      = BUSY_B;
          w_last_grant_nxt = PORT_B;
        end
      end
      BUSY_A:  if (w_complete || w_timeout) w_state_nxt = DONE_A;
      BUSY_B:  if (w_complete || w_timeout) w_state_nxt = DONE_B;
      DONE_A:  w_state_nxt = IDLE;
      DONE_B:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_err     <= 1'b0;
    end else if (w_complete) begin
      if (w_sel_is_read && w_busy_a) r_a_rdata <= m_rdata;
      if (w_sel_is_read && w_busy_b) r_b_rdata <= m_rdata;
    end else if (w_timeout) begin
      if (w_busy_a) r_a_rdata <= '0;
      if (w_busy_b) r_b_rdata <= '0;
      r_err <= 1'b1;
    end
  end

  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;
  assign err     = r_err;
  assign a_ready = ~w_req_a | (r_state == DONE_A);
  assign b_ready = ~w_req_b | (r_state == DONE_B);

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM controller port (r_en/w_en/address/wdata → rdata/ready) between two requesters.
- Port A is the MEM-stage data port; port B is a secondary master (boot loader / debug DMA).
- Each grant is held until the downstream access completes. Grants alternate round-robin on contention.
- A watchdog aborts any access the controller never completes.

Parameters:
- ADDR_W, 32, width of the word address passed to the SRAM controller.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, maximum BUSY cycles before an access is aborted (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_r_en  in  1  port A read request, held until a_ready.
- a_w_en  in  1  port A write request, held until a_ready.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_rdata  out  DATA_W  port A read data, registered.
- a_ready  out  1  port A not stalled.
- b_r_en, b_w_en, b_addr, b_wdata, b_rdata, b_ready: same as the A ports, for port B.
- m_r_en  out  1  read request to the SRAM controller.
- m_w_en  out  1  write request to the SRAM controller.
- m_addr  out  ADDR_W  address to the controller.
- m_wdata  out  DATA_W  write data to the controller.
- m_rdata  in  DATA_W  read data from the controller.
- m_ready  in  1  controller idle/complete; low while an access is in progress.
- err  out  1  sticky: a watchdog timeout has occurred.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=B, wd_cnt=0.
  - a_rdata=b_rdata=0, err=0.
  - m_r_en=m_w_en=0, m_addr=m_wdata=0.
- States: IDLE, BUSY_A, BUSY_B, DONE_A, DONE_B.
- IDLE:
  - m_*_en=0.
  - req_x = x_r_en|x_w_en.
  - If only one port requests, it wins. If both request, the port ≠ last_grant wins.
  - Next state is BUSY_winner; last_grant←winner.
  - No request: stay in IDLE.
- BUSY_x:
  - m_addr/m_wdata are muxed combinationally from port x.
  - m_w_en=x_w_en. m_r_en=x_r_en&~x_w_en (write has precedence when both are set).
  - The other port's signals are ignored.
  - wd_cnt increments each BUSY cycle and starts at 0 on entry.
  - Completion: m_ready=1 in any BUSY cycle with wd_cnt≥1. The first BUSY cycle never completes.
  - On completion: x_rdata←m_rdata if the access was a read; writes leave x_rdata unchanged. Next state DONE_x.
  - Timeout: wd_cnt==TIMEOUT_CYC-1 without completion. Then x_rdata←0, err←1, next state DONE_x.
  - Completion and timeout in the same cycle: completion wins and err is unchanged.
- DONE_x:
  - m_*_en=0 for exactly one cycle so the controller returns to idle.
  - Next state IDLE; wd_cnt←0.
- Ready outputs, combinational:
  - x_ready = ~req_x | (state==DONE_x).
  - A requesting port therefore stalls from the cycle it asserts until its DONE cycle.
- Latency with an uncontended port and a controller whose m_ready rises after N busy cycles: request in cycle 0; ready=1 and rdata valid in cycle N+2.
  - Minimum is cycle 3 (N=1).
  - Back-to-back accesses from one port are separated by the IDLE cycle.
- Fairness: with both ports continuously requesting, grants alternate A,B,A,B…
  - A wins the first tie after reset.
- A request dropped while BUSY is illegal (requesters hold until ready). The access still runs to completion or timeout.
- err clears only on reset.
- Reset mid-access: everything returns to reset values immediately. The controller shares rst, so no partial access is retried.

Decomposition:
- Shared package sram_arb_pkg:
  - arb_state_t enum (IDLE, BUSY_A, BUSY_B, DONE_A, DONE_B).
  - port_id_t enum (PORT_A, PORT_B).
  - Default ADDR_W/DATA_W/TIMEOUT_CYC constants.
- One sub-module, sram_arb_watchdog: the clear/enable counter with width $clog2(TIMEOUT_CYC+1) and a terminal-count output. It is reused by later controllers.

Test Plan:
- Reset: hold rst=0, then release → all outputs 0 and a_ready=b_ready=1. Then A read addr 0x10, controller returns 0xDEADBEEF after N=2 → a_ready=1 and a_rdata=0xDEADBEEF in cycle 4.
- Contention: A write (0x20, 0x1234) and B read (0x30) asserted the same cycle → A granted first (m_w_en, m_addr=0x20), b_ready=0 throughout. B is granted after DONE_A and returns the controller data.
- Round-robin: both ports request continuously for 6 accesses → grant order A,B,A,B,A,B. Each DONE pulse goes only to its owner.
- Both enables on port B (r_en=w_en=1) → m_w_en=1, m_r_en=0, b_rdata unchanged.
- Watchdog: TIMEOUT_CYC=8, m_ready held 0 → DONE after 8 BUSY cycles, a_rdata=0, err=1. err stays 1 over a later successful access.
- Reset mid-access: rst=0 in BUSY_B cycle 2 → m_*_en=0 immediately. After release, an A request is granted first (last_grant=B).
